rob_commit_nw: RTL and testbench

Parametrised N-wide reorder buffer and commit stage for the out-of-order core. It accepts renamed instructions in program order and records completion and exceptions from execute. Each cycle it retires up to `COMMIT_WIDTH` finished, exception-free instructions from the head, updating the retirement RAT and returning the old physical registers to the free list. An exception at the head triggers a one-cycle flush and retirement-RAT copy-back to the rename stage.

---
 rtl/rob_commit_nw.sv | 243 ++++++++++++++++++++++++
 tb/tb_rob_commit_nw.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_nw.sv
// rob_commit_nw: N-wide reorder buffer with in-order commit, retirement RAT
// and one-cycle exception flush with RAT copy-back to rename.
module rob_commit_nw #(
    parameter int unsigned ROB_ADDRWIDTH = 5,
    parameter int unsigned ARCH_WIDTH    = 5,
    parameter int unsigned PHYS_WIDTH    = 6,
    parameter int unsigned COMMIT_WIDTH  = 2
) (
    input  logic                                    CLK,
    input  logic                                    RESET,
    input  logic                                    FREEZE,
    input  logic                                    push_IN,
    input  logic                                    pushWrReg_IN,
    input  logic [ARCH_WIDTH-1:0]                   pushArch_IN,
    input  logic [PHYS_WIDTH-1:0]                   pushPhys_IN,
    input  logic [PHYS_WIDTH-1:0]                   pushOldPhys_IN,
    output logic                                    full_OUT,
    output logic [ROB_ADDRWIDTH-1:0]                tail_OUT,
    input  logic                                    fin_IN,
    input  logic [ROB_ADDRWIDTH-1:0]                finTag_IN,
    input  logic                                    finExc_IN,
    output logic [COMMIT_WIDTH-1:0]                 freeValid_OUT,
    output logic [COMMIT_WIDTH*PHYS_WIDTH-1:0]      freeReg_OUT,
    output logic [2:0]                              retCount_OUT,
    output logic                                    flushEm_OUT,
    output logic                                    copyRetRat_OUT,
    output logic [(1<<ARCH_WIDTH)*PHYS_WIDTH-1:0]   retRat_OUT
);

    localparam int unsigned DEPTH = 1 << ROB_ADDRWIDTH;
    localparam int unsigned NARCH = 1 << ARCH_WIDTH;
    localparam int unsigned CNT_W = ROB_ADDRWIDTH + 1;
    localparam int unsigned RET_W = 3;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e state_q, state_d;

    // Entry status bits (reset) and payload (no reset, qualified by valid)
    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [DEPTH-1:0]         fin_q, fin_d;
    logic [DEPTH-1:0]         exc_q, exc_d;
    logic [DEPTH-1:0]         wr_q, wr_d;
    logic [ARCH_WIDTH-1:0]    arch_q [DEPTH];
    logic [ARCH_WIDTH-1:0]    arch_d [DEPTH];
    logic [PHYS_WIDTH-1:0]    phys_q [DEPTH];
    logic [PHYS_WIDTH-1:0]    phys_d [DEPTH];
    logic [PHYS_WIDTH-1:0]    old_q  [DEPTH];
    logic [PHYS_WIDTH-1:0]    old_d  [DEPTH];

    logic [ROB_ADDRWIDTH-1:0] head_q, head_d;
    logic [ROB_ADDRWIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]         count_q, count_d;

    logic [PHYS_WIDTH-1:0]    ret_rat_q [NARCH];
    logic [PHYS_WIDTH-1:0]    ret_rat_d [NARCH];

    logic [COMMIT_WIDTH-1:0]            free_valid_q, free_valid_d;
    logic [COMMIT_WIDTH*PHYS_WIDTH-1:0] free_reg_q, free_reg_d;
    logic [RET_W-1:0]                   ret_count_q, ret_count_d;
    logic                               flush_q, flush_d;

    logic [ROB_ADDRWIDTH-1:0] slot_idx_c [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0]  slot_ret_c;
    logic [RET_W-1:0]         n_ret_c;
    logic                     head_exc_c;
    logic                     push_acc_c;
    logic                     fin_acc_c;

    // Commit scan: contiguous run of finished, exception-free entries from head
    always_comb begin
        logic go;
        slot_idx_c = '{default: '0};
        slot_ret_c = '0;
        n_ret_c    = '0;
        go         = (state_q == ST_RUN) && !FREEZE;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            slot_idx_c[k] = head_q + ROB_ADDRWIDTH'(k);
            if (go && valid_q[slot_idx_c[k]] && fin_q[slot_idx_c[k]] && !exc_q[slot_idx_c[k]]) begin
                slot_ret_c[k] = 1'b1;
                n_ret_c       = n_ret_c + RET_W'(1);
            end else begin
                go = 1'b0;
            end
        end
        head_exc_c = valid_q[head_q] && fin_q[head_q] && exc_q[head_q];
    end

    // Accept qualifiers for push and finish (pre-edge full, RUN only, not frozen)
    always_comb begin
        push_acc_c = push_IN && !full_OUT && (state_q == ST_RUN) && !FREEZE;
        fin_acc_c  = fin_IN && valid_q[finTag_IN] && (state_q == ST_RUN) && !FREEZE;
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: an excepting head forces a single flush cycle
    always_comb begin
        state_d = state_q;
        if (!FREEZE) begin
            case (state_q)
                ST_RUN:   if (head_exc_c) state_d = ST_FLUSH;
                ST_FLUSH: state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // FSM output: flush pulse registered so it is high exactly while in FLUSH
    always_comb begin
        flush_d = 1'b0;
        if ((state_q == ST_RUN) && (state_d == ST_FLUSH)) begin
            flush_d = 1'b1;
        end
    end

    // Datapath next state: finish, commit, push, flush clear
    always_comb begin
        valid_d      = valid_q;
        fin_d        = fin_q;
        exc_d        = exc_q;
        wr_d         = wr_q;
        arch_d       = arch_q;
        phys_d       = phys_q;
        old_d        = old_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        ret_rat_d    = ret_rat_q;
        free_valid_d = '0;
        free_reg_d   = free_reg_q;
        ret_count_d  = ret_count_q;

        if (!FREEZE) begin
            if (state_q == ST_FLUSH) begin
                valid_d     = '0;
                head_d      = '0;
                tail_d      = '0;
                count_d     = '0;
                ret_count_d = '0;
                free_reg_d  = '0;
            end else begin
                if (fin_acc_c) begin
                    fin_d[finTag_IN] = 1'b1;
                    exc_d[finTag_IN] = exc_q[finTag_IN] | finExc_IN;
                end

                free_reg_d  = '0;
                ret_count_d = n_ret_c;
                // Ascending slot order lets the youngest writer of an arch reg win
                for (int k = 0; k < COMMIT_WIDTH; k++) begin
                    if (slot_ret_c[k]) begin
                        valid_d[slot_idx_c[k]] = 1'b0;
                        fin_d[slot_idx_c[k]]   = 1'b0;
                        exc_d[slot_idx_c[k]]   = 1'b0;
                        if (wr_q[slot_idx_c[k]]) begin
                            ret_rat_d[arch_q[slot_idx_c[k]]]           = phys_q[slot_idx_c[k]];
                            free_valid_d[k]                            = 1'b1;
                            free_reg_d[k*PHYS_WIDTH +: PHYS_WIDTH]     = old_q[slot_idx_c[k]];
                        end
                    end
                end
                head_d = head_q + ROB_ADDRWIDTH'(n_ret_c);

                if (push_acc_c) begin
                    valid_d[tail_q] = 1'b1;
                    fin_d[tail_q]   = 1'b0;
                    exc_d[tail_q]   = 1'b0;
                    wr_d[tail_q]    = pushWrReg_IN;
                    arch_d[tail_q]  = pushArch_IN;
                    phys_d[tail_q]  = pushPhys_IN;
                    old_d[tail_q]   = pushOldPhys_IN;
                    tail_d          = tail_q + ROB_ADDRWIDTH'(1);
                end

                count_d = count_q + CNT_W'(push_acc_c) - CNT_W'(n_ret_c);
            end
        end
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            valid_q      <= '0;
            fin_q        <= '0;
            exc_q        <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            free_valid_q <= '0;
            free_reg_q   <= '0;
            ret_count_q  <= '0;
            flush_q      <= 1'b0;
            for (int i = 0; i < NARCH; i++) begin
                ret_rat_q[i] <= PHYS_WIDTH'(i);
            end
        end else begin
            valid_q      <= valid_d;
            fin_q        <= fin_d;
            exc_q        <= exc_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            free_valid_q <= free_valid_d;
            free_reg_q   <= free_reg_d;
            ret_count_q  <= ret_count_d;
            flush_q      <= flush_d;
            ret_rat_q    <= ret_rat_d;
        end
    end

    // Entry payload storage
    always_ff @(posedge CLK) begin
        wr_q   <= wr_d;
        arch_q <= arch_d;
        phys_q <= phys_d;
        old_q  <= old_d;
    end

    assign full_OUT       = (count_q == CNT_W'(DEPTH));
    assign tail_OUT       = tail_q;
    assign freeValid_OUT  = free_valid_q;
    assign freeReg_OUT    = free_reg_q;
    assign retCount_OUT   = ret_count_q;
    assign flushEm_OUT    = flush_q;
    assign copyRetRat_OUT = flush_q;

    // Flatten retirement RAT for the rename copy-back bus
    for (genvar g = 0; g < NARCH; g++) begin : g_rat
        assign retRat_OUT[g*PHYS_WIDTH +: PHYS_WIDTH] = ret_rat_q[g];
    end

endmodule

// File: tb/tb_rob_commit_nw.sv
// tb_rob_commit_nw: directed stimulus with a queued scoreboard for retire/flush events.
module tb_rob_commit_nw;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         FREEZE;
    logic         push_IN;
    logic         pushWrReg_IN;
    logic [4:0]   pushArch_IN;
    logic [5:0]   pushPhys_IN;
    logic [5:0]   pushOldPhys_IN;
    logic         full_OUT;
    logic [4:0]   tail_OUT;
    logic         fin_IN;
    logic [4:0]   finTag_IN;
    logic         finExc_IN;
    logic [1:0]   freeValid_OUT;
    logic [11:0]  freeReg_OUT;
    logic [2:0]   retCount_OUT;
    logic         flushEm_OUT;
    logic         copyRetRat_OUT;
    logic [191:0] retRat_OUT;

    rob_commit_nw dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .FREEZE         (FREEZE),
        .push_IN        (push_IN),
        .pushWrReg_IN   (pushWrReg_IN),
        .pushArch_IN    (pushArch_IN),
        .pushPhys_IN    (pushPhys_IN),
        .pushOldPhys_IN (pushOldPhys_IN),
        .full_OUT       (full_OUT),
        .tail_OUT       (tail_OUT),
        .fin_IN         (fin_IN),
        .finTag_IN      (finTag_IN),
        .finExc_IN      (finExc_IN),
        .freeValid_OUT  (freeValid_OUT),
        .freeReg_OUT    (freeReg_OUT),
        .retCount_OUT   (retCount_OUT),
        .flushEm_OUT    (flushEm_OUT),
        .copyRetRat_OUT (copyRetRat_OUT),
        .retRat_OUT     (retRat_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  cnt;
        logic [1:0]  fv;
        logic [11:0] fr;
        logic        flush;
        int          rat_idx;
        logic [5:0]  rat_val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] rat(input int i);
        return retRat_OUT[i*6 +: 6];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_push(input logic [4:0] a, input logic [5:0] p, input logic [5:0] o);
        push_IN = 1'b1; pushWrReg_IN = 1'b1;
        pushArch_IN = a; pushPhys_IN = p; pushOldPhys_IN = o;
        tick();
        push_IN = 1'b0;
    endtask

    task automatic do_fin(input logic [4:0] t, input logic e);
        fin_IN = 1'b1; finTag_IN = t; finExc_IN = e;
        tick();
        fin_IN = 1'b0; finExc_IN = 1'b0;
    endtask

    task automatic expect_ret(input logic [2:0] c, input logic [1:0] fv, input logic [11:0] fr,
                              input int idx, input logic [5:0] val);
        exp_t e;
        e.cnt = c; e.fv = fv; e.fr = fr; e.flush = 1'b0; e.rat_idx = idx; e.rat_val = val;
        exp_q.push_back(e);
    endtask

    task automatic expect_flush();
        exp_t e;
        e.cnt = 3'd0; e.fv = 2'b00; e.fr = 12'd0; e.flush = 1'b1; e.rat_idx = -1; e.rat_val = 6'd0;
        exp_q.push_back(e);
    endtask

    // Monitor: every retire or flush presentation is matched against the queue
    always @(negedge CLK) begin
        if (retCount_OUT != 3'd0 || freeValid_OUT != 2'b00 || flushEm_OUT || copyRetRat_OUT) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event retCount=%0d freeValid=%b flush=%b copy=%b at %0t",
                         retCount_OUT, freeValid_OUT, flushEm_OUT, copyRetRat_OUT, $time);
            end else begin
                logic [11:0] m;
                mon_e = exp_q.pop_front();
                m = {{6{mon_e.fv[1]}}, {6{mon_e.fv[0]}}};
                chk("retCount", 32'(retCount_OUT), 32'(mon_e.cnt));
                chk("freeValid", 32'(freeValid_OUT), 32'(mon_e.fv));
                chk("freeReg", 32'(freeReg_OUT & m), 32'(mon_e.fr));
                chk("flushEm", 32'(flushEm_OUT), 32'(mon_e.flush));
                chk("copyRetRat", 32'(copyRetRat_OUT), 32'(mon_e.flush));
                if (mon_e.rat_idx >= 0) begin
                    chk("retRat_evt", 32'(rat(mon_e.rat_idx)), 32'(mon_e.rat_val));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b0; FREEZE = 1'b0; push_IN = 1'b0; pushWrReg_IN = 1'b0;
        pushArch_IN = '0; pushPhys_IN = '0; pushOldPhys_IN = '0;
        fin_IN = 1'b0; finTag_IN = '0; finExc_IN = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_rat7", 32'(rat(7)), 32'd7);
        chk("rst_full", 32'(full_OUT), 32'd0);
        chk("rst_tail", 32'(tail_OUT), 32'd0);
        chk("rst_flush", 32'(flushEm_OUT), 32'd0);
        chk("rst_copy", 32'(copyRetRat_OUT), 32'd0);
        chk("rst_freeValid", 32'(freeValid_OUT), 32'd0);
        chk("rst_retCount", 32'(retCount_OUT), 32'd0);
        RESET = 1'b1;
        tick();

        // Basic in-order two-wide retire
        for (int i = 0; i < 4; i++) begin
            chk("tail_basic", 32'(tail_OUT), 32'(i));
            do_push(5'(i + 1), 6'(33 + i), 6'(i + 1));
        end
        do_fin(5'd1, 1'b0);
        do_fin(5'd0, 1'b0);
        expect_ret(3'd2, 2'b11, 12'h081, 1, 6'd33);
        tick();
        chk("rat2_basic", 32'(rat(2)), 32'd34);
        tick();
        chk("idle_retCount", 32'(retCount_OUT), 32'd0);
        chk("idle_freeValid", 32'(freeValid_OUT), 32'd0);
        do_fin(5'd2, 1'b0);
        expect_ret(3'd1, 2'b01, 12'h003, 3, 6'd35);
        do_fin(5'd3, 1'b0);
        expect_ret(3'd1, 2'b01, 12'h004, 4, 6'd36);
        tick();

        // Same arch register retired twice in one cycle: youngest wins
        do_push(5'd5, 6'd40, 6'd5);
        do_push(5'd5, 6'd41, 6'd40);
        do_fin(5'd5, 1'b0);
        do_fin(5'd4, 1'b0);
        expect_ret(3'd2, 2'b11, 12'hA05, 5, 6'd41);
        tick();

        // Fill to full with tail wrap, drop on full, retire + push at pre-edge full
        for (int j = 0; j < 32; j++) begin
            chk("tail_fill", 32'(tail_OUT), 32'((6 + j) % 32));
            chk("full_fill", 32'(full_OUT), 32'd0);
            do_push(5'd6, 6'(16 + j), 6'(j));
        end
        chk("full_set", 32'(full_OUT), 32'd1);
        chk("tail_full", 32'(tail_OUT), 32'd6);
        do_push(5'd6, 6'd63, 6'd63);
        chk("tail_drop", 32'(tail_OUT), 32'd6);
        chk("full_drop", 32'(full_OUT), 32'd1);
        do_fin(5'd7, 1'b0);
        do_fin(5'd6, 1'b0);
        expect_ret(3'd2, 2'b11, 12'h040, 6, 6'd17);
        do_push(5'd7, 6'd50, 6'd51);
        chk("tail_prefull", 32'(tail_OUT), 32'd6);
        chk("full_after_ret", 32'(full_OUT), 32'd0);
        do_push(5'd7, 6'd50, 6'd51);
        chk("tail_31", 32'(tail_OUT), 32'd7);
        chk("full_31", 32'(full_OUT), 32'd0);
        do_push(5'd7, 6'd52, 6'd53);
        chk("tail_32", 32'(tail_OUT), 32'd8);
        chk("full_32", 32'(full_OUT), 32'd1);

        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        chk("rst2_tail", 32'(tail_OUT), 32'd0);
        chk("rst2_full", 32'(full_OUT), 32'd0);
        chk("rst2_rat6", 32'(rat(6)), 32'd6);
        tick();

        // Freeze ignores push and finish
        FREEZE = 1'b1;
        do_push(5'd3, 6'd60, 6'd3);
        chk("freeze_tail", 32'(tail_OUT), 32'd0);
        FREEZE = 1'b0;

        // Exception behind a good head: head retires, then a one-cycle flush
        do_push(5'd9, 6'd20, 6'd9);
        do_push(5'd10, 6'd21, 6'd10);
        do_push(5'd11, 6'd22, 6'd11);
        do_fin(5'd1, 1'b1);
        do_fin(5'd0, 1'b0);
        expect_ret(3'd1, 2'b01, 12'h009, 9, 6'd20);
        tick();
        expect_flush();
        tick();
        chk("flush_high", 32'(flushEm_OUT), 32'd1);
        do_push(5'd12, 6'd23, 6'd12);
        chk("post_flush_pulse", 32'(flushEm_OUT), 32'd0);
        chk("post_flush_copy", 32'(copyRetRat_OUT), 32'd0);
        chk("post_flush_tail", 32'(tail_OUT), 32'd0);
        chk("post_flush_full", 32'(full_OUT), 32'd0);
        chk("post_flush_rat9", 32'(rat(9)), 32'd20);
        chk("post_flush_rat10", 32'(rat(10)), 32'd10);
        chk("post_flush_rat11", 32'(rat(11)), 32'd11);
        do_push(5'd12, 6'd30, 6'd12);
        chk("push_after_flush", 32'(tail_OUT), 32'd1);

        // Reset asserted during FLUSH
        do_fin(5'd0, 1'b1);
        expect_flush();
        tick();
        RESET = 1'b0;
        tick();
        chk("rstf_flush", 32'(flushEm_OUT), 32'd0);
        chk("rstf_copy", 32'(copyRetRat_OUT), 32'd0);
        chk("rstf_tail", 32'(tail_OUT), 32'd0);
        chk("rstf_full", 32'(full_OUT), 32'd0);
        chk("rstf_rat9", 32'(rat(9)), 32'd9);
        chk("rstf_rat7", 32'(rat(7)), 32'd7);
        chk("rstf_retCount", 32'(retCount_OUT), 32'd0);
        RESET = 1'b1;
        tick(); tick(); tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
